// File: rtl/banco_registradores_pkg.sv
// Shared defaults and architectural register indices for the MIPS-style register bank.
// Imported by the interface, the read-select sub-module and the top.
package banco_registradores_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W_DEF-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W_DEF-1:0] REG_RA   = 5'd31;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/banco_registradores_if.sv
// Register bank bus: one write port and two combinational read ports.
// The datapath drives the master side; the register bank is the slave.
interface banco_registradores_if
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              RegWrite;
    logic [ADDR_W-1:0] RegEscrita;
    logic [DATA_W-1:0] DadoEscrita;
    logic [ADDR_W-1:0] RegLeitura1;
    logic [ADDR_W-1:0] RegLeitura2;
    logic [DATA_W-1:0] DadoLido1;
    logic [DATA_W-1:0] DadoLido2;

    modport master (
        output RegWrite, RegEscrita, DadoEscrita, RegLeitura1, RegLeitura2,
        input  DadoLido1, DadoLido2
    );

    modport slave (
        input  RegWrite, RegEscrita, DadoEscrita, RegLeitura1, RegLeitura2,
        output DadoLido1, DadoLido2
    );

endinterface

// File: rtl/banco_registradores_leitura_bypass.sv
// Per-port read select: forces index 0 to zero and, with BYPASS_ESCRITA_EN defined,
// forwards same-cycle write data to a matching read index.
module leitura_bypass
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_stored,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic rd_is_zero;
    assign rd_is_zero = (rd_idx == ADDR_W'(REG_ZERO));

`ifdef BYPASS_ESCRITA_EN
    logic fwd_hit;
    // Forwarding never targets r0 and is held off while the bank is in reset.
    assign fwd_hit = reset_n && wr_en && (wr_idx != ADDR_W'(REG_ZERO)) && (wr_idx == rd_idx);

    always_comb begin
        rd_data = rd_stored;
        if (rd_is_zero) begin
            rd_data = '0;
        end else if (fwd_hit) begin
            rd_data = wr_data;
        end
    end
`else
    logic unused_bypass;
    assign unused_bypass = &{1'b0, reset_n, wr_en, wr_idx, wr_data};

    always_comb begin
        rd_data = rd_stored;
        if (rd_is_zero) begin
            rd_data = '0;
        end
    end
`endif

endmodule

// File: rtl/banco_registradores.sv
// MIPS-style register bank: NUM_REGS x DATA_W, one write port, two combinational reads.
// Optional same-cycle write forwarding is enabled by defining BYPASS_ESCRITA_EN.
module banco_registradores
    import banco_registradores_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    banco_registradores_if.slave  bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_valid;

    assign wr_valid = bus.RegWrite && (bus.RegEscrita != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_valid) begin
            regs_d[bus.RegEscrita] = bus.DadoEscrita;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    leitura_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_leitura1 (
        .reset_n   (reset_n),
        .rd_idx    (bus.RegLeitura1),
        .rd_stored (regs_q[bus.RegLeitura1]),
        .wr_en     (bus.RegWrite),
        .wr_idx    (bus.RegEscrita),
        .wr_data   (bus.DadoEscrita),
        .rd_data   (bus.DadoLido1)
    );

    leitura_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_leitura2 (
        .reset_n   (reset_n),
        .rd_idx    (bus.RegLeitura2),
        .rd_stored (regs_q[bus.RegLeitura2]),
        .wr_en     (bus.RegWrite),
        .wr_idx    (bus.RegEscrita),
        .wr_data   (bus.DadoEscrita),
        .rd_data   (bus.DadoLido2)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores against an array-based register model.
// Builds with or without BYPASS_ESCRITA_EN; expectations follow the macro.
module tb_banco_registradores;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] model [32];

    banco_registradores_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    banco_registradores #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Expected read value for the current cycle, from the stored model plus the forwarding rule.
    function automatic logic [31:0] exp_now(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (!reset_n) return 32'h0;
`ifdef BYPASS_ESCRITA_EN
        if (bus.RegWrite && bus.RegEscrita != 5'd0 && bus.RegEscrita == idx) return bus.DadoEscrita;
`endif
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data, input logic we);
        bus.RegWrite    = we;
        bus.RegEscrita  = idx;
        bus.DadoEscrita = data;
        @(posedge clock);
        #1;
        if (we && idx != 5'd0 && reset_n) model[idx] = data;
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegEscrita = '0;
        bus.DadoEscrita = '0;
        bus.RegLeitura1 = '0;
        bus.RegLeitura2 = '0;
        clear_model();
        #12;
        for (int i = 0; i < 32; i += 7) begin
            bus.RegLeitura1 = 5'(i);
            bus.RegLeitura2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.DadoLido1 !== 32'h0 || bus.DadoLido2 !== 32'h0) begin
                errors++;
                $display("[TB] FAIL reset_read idx=%0d got %h/%h exp 0", i, bus.DadoLido1, bus.DadoLido2);
            end
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        // First edge after deassertion must accept a write.
        write_reg(5'd4, 32'hCAFE0004, 1'b1);
        bus.RegLeitura1 = 5'd4;
        #1;
        checks++;
        if (bus.DadoLido1 !== 32'hCAFE0004) begin
            errors++;
            $display("[TB] FAIL first_write_after_reset got %h exp %h", bus.DadoLido1, 32'hCAFE0004);
        end
    endtask

    task automatic test_zero_write();
        write_reg(5'd0, 32'h12345678, 1'b1);
        bus.RegLeitura1 = 5'd0;
        bus.RegLeitura2 = 5'd0;
        #1;
        checks++;
        if (bus.DadoLido1 !== 32'h0 || bus.DadoLido2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL zero_write got %h/%h exp 0", bus.DadoLido1, bus.DadoLido2);
        end
    endtask

    task automatic test_dual_read_ra();
        write_reg(5'd31, 32'hA5A5A5A5, 1'b1);
        bus.RegLeitura1 = 5'd31;
        bus.RegLeitura2 = 5'd31;
        #1;
        checks++;
        if (bus.DadoLido1 !== 32'hA5A5A5A5 || bus.DadoLido2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL dual_read_r31 got %h/%h exp a5a5a5a5", bus.DadoLido1, bus.DadoLido2);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_same;
        write_reg(5'd8, 32'h11, 1'b1);
`ifdef BYPASS_ESCRITA_EN
        exp_same = 32'h22;
`else
        exp_same = 32'h11;
`endif
        bus.RegWrite    = 1'b1;
        bus.RegEscrita  = 5'd8;
        bus.DadoEscrita = 32'h22;
        bus.RegLeitura1 = 5'd8;
        bus.RegLeitura2 = 5'd9;
        #1;
        checks++;
        if (bus.DadoLido1 !== exp_same) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle got %h exp %h", bus.DadoLido1, exp_same);
        end
        checks++;
        if (bus.DadoLido2 !== model[9]) begin
            errors++;
            $display("[TB] FAIL bypass_other_port got %h exp %h", bus.DadoLido2, model[9]);
        end
        @(posedge clock);
        #1;
        model[8] = 32'h22;
        bus.RegWrite = 1'b0;
        checks++;
        if (bus.DadoLido1 !== 32'h22) begin
            errors++;
            $display("[TB] FAIL bypass_after_edge got %h exp 22", bus.DadoLido1);
        end
        // Forwarding must never reach index 0.
        bus.RegWrite    = 1'b1;
        bus.RegEscrita  = 5'd0;
        bus.DadoEscrita = 32'hFFFF0000;
        bus.RegLeitura2 = 5'd0;
        #1;
        checks++;
        if (bus.DadoLido2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL bypass_r0 got %h exp 0", bus.DadoLido2);
        end
        @(posedge clock);
        #1;
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_write_disable();
        write_reg(5'd3, 32'hFFFFFFFF, 1'b0);
        bus.RegLeitura1 = 5'd3;
        #1;
        checks++;
        if (bus.DadoLido1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_disabled_r3 got %h exp 0", bus.DadoLido1);
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i), 1'b1);
        for (int i = 0; i < 32; i++) begin
            bus.RegLeitura1 = 5'(i);
            bus.RegLeitura2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.DadoLido1 !== 32'(i) || bus.DadoLido2 !== 32'(31 - i)) begin
                errors++;
                $display("[TB] FAIL sweep idx=%0d got %h/%h exp %h/%h",
                         i, bus.DadoLido1, bus.DadoLido2, 32'(i), 32'(31 - i));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            bus.RegWrite    = 1'($urandom_range(0, 1));
            bus.RegEscrita  = 5'($urandom_range(0, 31));
            bus.DadoEscrita = $urandom;
            bus.RegLeitura1 = ($urandom_range(0, 3) == 0) ? bus.RegEscrita : 5'($urandom_range(0, 31));
            bus.RegLeitura2 = 5'($urandom_range(0, 31));
            #1;
            e1 = exp_now(bus.RegLeitura1);
            e2 = exp_now(bus.RegLeitura2);
            checks++;
            if (bus.DadoLido1 !== e1 || bus.DadoLido2 !== e2) begin
                errors++;
                $display("[TB] FAIL random n=%0d rd=%0d/%0d got %h/%h exp %h/%h", n,
                         bus.RegLeitura1, bus.RegLeitura2, bus.DadoLido1, bus.DadoLido2, e1, e2);
            end
            @(posedge clock);
            #1;
            if (bus.RegWrite && bus.RegEscrita != 5'd0) model[bus.RegEscrita] = bus.DadoEscrita;
        end
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_async_reset();
        write_reg(5'd5, 32'hDEADBEEF, 1'b1);
        bus.RegLeitura1 = 5'd5;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.DadoLido1 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL async_reset_r5 got %h exp 0", bus.DadoLido1);
        end
        clear_model();
        // A write during reset is discarded and never forwarded.
        bus.RegWrite    = 1'b1;
        bus.RegEscrita  = 5'd7;
        bus.DadoEscrita = 32'h77777777;
        bus.RegLeitura2 = 5'd7;
        #1;
        checks++;
        if (bus.DadoLido2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_no_bypass got %h exp 0", bus.DadoLido2);
        end
        @(posedge clock);
        #1;
        bus.RegWrite = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.DadoLido2 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL write_during_reset got %h exp 0", bus.DadoLido2);
        end
    endtask

    initial begin
        test_reset();
        test_zero_write();
        test_dual_read_ra();
        test_bypass();
        test_write_disable();
        test_sweep();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registradores.md
BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of each register and data port.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the number of architectural registers.
REQ-003 Parameter ADDR_W, default 5, SHALL set the register index width; NUM_REGS SHALL equal 2**ADDR_W.
REQ-004 clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 RegWrite  input  1  SHALL enable the write port when high.
REQ-007 RegEscrita  input  ADDR_W  SHALL give the write destination index.
REQ-008 DadoEscrita  input  DATA_W  SHALL carry write-back data (the MemtoReg mux output).
REQ-009 RegLeitura1  input  ADDR_W  SHALL give the read port 1 index (rs).
REQ-010 RegLeitura2  input  ADDR_W  SHALL give the read port 2 index (rt).
REQ-011 DadoLido1  output  DATA_W  SHALL return the read port 1 data.
REQ-012 DadoLido2  output  DATA_W  SHALL return the read port 2 data.

Function
REQ-013 On a rising clock edge with RegWrite=1 and RegEscrita!=0, the block SHALL store DadoEscrita in register RegEscrita.
REQ-014 Writes with RegWrite=0 or RegEscrita=0 SHALL leave all registers unchanged.
REQ-015 Register 0 SHALL always read as 0, regardless of any write attempt.
REQ-016 Reads SHALL be combinational: DadoLido1 and DadoLido2 SHALL reflect the indexed registers in the same cycle, with zero-cycle latency.
REQ-017 Both read ports SHALL be independent; identical indices on both ports SHALL return identical data.
REQ-018 A written value SHALL be visible on the read ports from the cycle after the write edge.
REQ-019 Only one write per cycle SHALL occur; a write takes effect at the edge only, with no partial or byte writes.

Reset
REQ-020 While reset_n=0, all NUM_REGS registers SHALL be cleared to 0 asynchronously, so DadoLido1 and DadoLido2 read 0 for any index.
REQ-021 A write that coincides with reset_n=0 SHALL be discarded.
REQ-022 Deassertion of reset_n SHALL take effect at the next rising edge; the first write is accepted on that edge if RegWrite=1.

Configuration
REQ-023 Macro BYPASS_ESCRITA_EN, when defined, SHALL forward DadoEscrita to a read port in the same cycle when RegWrite=1, RegEscrita!=0 and RegEscrita equals that port's index.
REQ-024 Without BYPASS_ESCRITA_EN, same-cycle read of a register being written SHALL return the old stored value.
REQ-025 Bypass SHALL never apply to index 0 and SHALL be suppressed while reset_n=0.

Structure
REQ-026 A shared package SHALL hold DATA_W/ADDR_W defaults and index constants REG_ZERO=0, REG_SP=29 and REG_RA=31.
REQ-027 Per-port read selection (zero check plus optional bypass) SHALL be a sub-module leitura_bypass, instantiated once per read port.

Verification
REQ-028 The bench SHALL assert reset_n=0 mid-operation after register 5 holds 0xDEADBEEF, then read index 5 -> 0x00000000 immediately, without waiting for a clock edge.
REQ-029 The bench SHALL write 0x12345678 to register 0, then read both ports at index 0 -> 0x00000000.
REQ-030 The bench SHALL write 0xA5A5A5A5 to register 31, then the next cycle read port 1=31 and port 2=31 -> both 0xA5A5A5A5.
REQ-031 The bench SHALL, with register 8=0x11, apply RegWrite=1, RegEscrita=8, DadoEscrita=0x22 and port 1=8 in the same cycle -> 0x22 with BYPASS_ESCRITA_EN defined, 0x11 without it; after the edge -> 0x22 in both builds.
REQ-032 The bench SHALL apply RegWrite=0, RegEscrita=3, DadoEscrita=0xFFFFFFFF -> register 3 remains 0.
REQ-033 The bench SHALL write indices 1..31 with values equal to their index, then sweep both ports across all indices -> DadoLido equals index, and index 0 reads 0.
